cache_mem_ctrl: RTL and testbench
=================================

// Module: cache_mem_ctrl
// PURPOSE
// Direct-mapped, write-back, write-allocate cache controller between the CPU load/store port and
// the asynchronous byte-addressed RAM. Initiator end of the RAM protocol: drives MRd (active-low read),
// CMWr (active-high write), Addr, MDataIn; samples MDataOut. Serialises line refills/evictions as word beats.
// PARAMETERS
// INDEX_BITS  3  log2(number of lines); 8 lines
// BEAT_BITS   2  log2(words per line); 4 x 32-bit words = 16-byte line
// PORTS
// CLK       in   1   single clock, rising edge
// RST_n     in   1   asynchronous, active-low reset
// CReq      in   1   CPU request strobe, sampled in IDLE only
// CWr       in   1   1=store, 0=load (qualified by CReq)
// CAddr     in   32  CPU byte address; [1:0] ignored (word aligned)
// CDataIn   in   32  store data
// CDataOut  out  32  load data, valid while CReady=1
// CReady    out  1   one-cycle completion pulse (load and store)
// Busy      out  1   1 from accept until cycle of CReady
// MRd       out  1   RAM read enable, active-low
// CMWr      out  1   RAM write enable, active-high
// Addr      out  32  RAM byte address, always line-beat aligned ({tag,index,beat,2'b00})
// MDataIn   out  32  RAM write data
// MDataOut  in   32  RAM read data (combinational, settles < 1 cycle after Addr)
// BEHAVIOUR
// - Reset (async): state IDLE; valid/dirty all 0; MRd=1, CMWr=0, Addr=0, MDataIn=0, CDataOut=0,
//   CReady=0, Busy=0. Reset mid-beat aborts cleanly: write enable drops, partial line never marked valid.
// - All memory-side outputs come from flops (RAM is level-sensitive: no glitches on CMWr/Addr).
//   Addr, MDataIn, CMWr change on the same edge; CMWr never 1 outside WB.
// - Address split: tag=CAddr[31:INDEX_BITS+BEAT_BITS+2], index, beat=CAddr[BEAT_BITS+1:2].
// - IDLE: CReq=1 -> latch CAddr/CWr/CDataIn, Busy<=1, -> LOOKUP. CReq while Busy ignored.
// - LOOKUP: hit=valid&tag match. Hit load: CDataOut<=word, CReady<=1 next cycle, -> IDLE.
//   Hit store: word<=CDataIn, dirty<=1, CReady<=1, -> IDLE. Miss&dirty -> WB; miss&clean -> FILL.
// - WB: 4 beats, one per cycle, beat 0..3: CMWr=1, MRd=1, Addr={old_tag,index,beat,00}, MDataIn=word[beat].
//   After beat 3 -> FILL (CMWr drops on the FILL entry edge).
// - FILL: 4 beats: MRd=0, CMWr=0, Addr={new_tag,index,beat,00}; word[beat]<=MDataOut at end of beat.
//   After beat 3: valid<=1, tag<=new, dirty<=0, MRd<=1, -> LOOKUP (re-lookup hits; store then dirties).
// - Latency from CReq edge to CReady high: hit 2 cycles; clean miss 7; dirty miss 11.
// - Beat counter BEAT_BITS wide, wraps 3->0; state advance on wrap only.
// - CReady/CDataOut: CReady low every cycle except completion; CDataOut holds last load value.
// STRUCTURE
// - cache_pkg: state enum (IDLE, LOOKUP, WB, FILL), TAG_W/INDEX_W/BEAT_W localparams, field-extract functions.
// - Sub-module cache_line_store: valid/dirty/tag arrays + data array (LINES x 4 words), one write port,
//   async read by index; resets valid/dirty only.
// - Top: FSM, beat counter, request latch, registered memory-side drivers.
// TESTING (bench RAM model: byte array, combinational read, level write)
// 1. Reset: hold RST_n=0 -> MRd=1, CMWr=0, CReady=0, Busy=0; release, no memory activity while CReq=0.
// 2. Load 0x00 with RAM word0=0x1100F0F0 -> 4 FILL beats Addr 0x00,04,08,0C with MRd=0; CReady cycle 7,
//    CDataOut=0x1100F0F0.
// 3. Load 0x04 after test 2 -> hit, no RAM activity, CReady cycle 2, CDataOut=RAM word at 0x04.
// 4. Store 0xDEADBEEF to 0x08 (hit) then load 0x88 (same index 0, different tag) -> WB beats writing
//    Addr 0x00..0x0C with CMWr=1, RAM[0x08]=0xDEADBEEF, then FILL 0x80..0x8C; CReady cycle 11.
// 5. Reset asserted during FILL beat 2 -> outputs at reset values immediately; load 0x00 after release misses.
// 6. CReq pulsed while Busy -> ignored; only first request completes, exactly one CReady pulse.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, geometry and address helpers for the direct-mapped cache controller.
package cache_pkg;

  localparam int INDEX_BITS = 3;
  localparam int BEAT_BITS  = 2;

  localparam int INDEX_W  = INDEX_BITS;
  localparam int BEAT_W   = BEAT_BITS;
  localparam int OFFSET_W = INDEX_W + BEAT_W + 2;
  localparam int TAG_W    = 32 - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;
  localparam int WORDS    = 1 << BEAT_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_FILL
  } state_e;

  function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] addr);
    return addr[31:OFFSET_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [31:0] addr);
    return addr[OFFSET_W-1:BEAT_W+2];
  endfunction

  function automatic logic [BEAT_W-1:0] get_beat(input logic [31:0] addr);
    return addr[BEAT_W+1:2];
  endfunction

  // Line-beat aligned RAM address: {tag, index, beat, 2'b00}.
  function automatic logic [31:0] make_addr(input logic [TAG_W-1:0]   tag,
                                            input logic [INDEX_W-1:0] index,
                                            input logic [BEAT_W-1:0]  beat);
    return {tag, index, beat, 2'b00};
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Line storage: valid/dirty/tag per line plus LINES x WORDS data words.
// Single write port, asynchronous read of a whole line by index.
module cache_line_store
  import cache_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [INDEX_W-1:0]          i_rd_index,
  output logic                        o_rd_valid,
  output logic                        o_rd_dirty,
  output logic [TAG_W-1:0]            o_rd_tag,
  output logic [WORDS-1:0][31:0]      o_rd_line,
  input  logic                        i_wr_en,
  input  logic [INDEX_W-1:0]          i_wr_index,
  input  logic [BEAT_W-1:0]           i_wr_beat,
  input  logic [31:0]                 i_wr_data,
  input  logic [TAG_W-1:0]            i_wr_tag,
  input  logic                        i_fill_done,
  input  logic                        i_set_dirty
);

  logic [LINES-1:0]         r_valid;
  logic [LINES-1:0]         r_dirty;
  logic [TAG_W-1:0]         r_tag  [LINES];
  logic [WORDS-1:0][31:0]   r_data [LINES];

  // Line status bits: a refill marks the line valid and clean, a store hit dirties it.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_fill_done) begin
        r_valid[i_wr_index] <= 1'b1;
        r_dirty[i_wr_index] <= 1'b0;
      end
      if (i_set_dirty) begin
        r_dirty[i_wr_index] <= 1'b1;
      end
    end
  end

  // Tag and data payload writes.
  // NOTE: payload arrays are not reset; valid=0 makes their contents irrelevant and keeps them RAM-mappable.
  always_ff @(posedge clk) begin
    if (i_fill_done) begin
      r_tag[i_wr_index] <= i_wr_tag;
    end
    if (i_wr_en) begin
      r_data[i_wr_index][i_wr_beat] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_dirty = r_dirty[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_line  = r_data[i_rd_index];

endmodule

// File: rtl/cache_mem_ctrl.sv
// Direct-mapped write-back write-allocate cache controller. Drives the RAM with
// registered MRd/CMWr/Addr/MDataIn and moves whole lines as WORDS word beats.
module cache_mem_ctrl
  import cache_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        CReq,
  input  logic        CWr,
  input  logic [31:0] CAddr,
  input  logic [31:0] CDataIn,
  output logic [31:0] CDataOut,
  output logic        CReady,
  output logic        Busy,
  output logic        MRd,
  output logic        CMWr,
  output logic [31:0] Addr,
  output logic [31:0] MDataIn,
  input  logic [31:0] MDataOut
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = '1;

  state_e               r_state;
  state_e               w_next_state;

  logic                 r_req_wr;
  logic [TAG_W-1:0]     r_req_tag;
  logic [INDEX_W-1:0]   r_req_index;
  logic [BEAT_W-1:0]    r_req_beat;
  logic [31:0]          r_req_data;

  logic [BEAT_W-1:0]    r_beat;
  logic                 r_mrd;
  logic                 r_cmwr;
  logic [31:0]          r_addr;
  logic [31:0]          r_mdatain;
  logic [31:0]          r_cdataout;
  logic                 r_cready;
  logic                 r_busy;

  logic [BEAT_W-1:0]    w_nxt_beat;
  logic                 w_nxt_mrd;
  logic                 w_nxt_cmwr;
  logic [31:0]          w_nxt_addr;
  logic [31:0]          w_nxt_mdatain;
  logic [31:0]          w_nxt_cdataout;
  logic                 w_nxt_cready;
  logic                 w_nxt_busy;

  logic                 w_st_we;
  logic [BEAT_W-1:0]    w_st_beat;
  logic [31:0]          w_st_data;
  logic                 w_st_fill_done;
  logic                 w_st_set_dirty;

  logic                 w_valid;
  logic                 w_dirty;
  logic [TAG_W-1:0]     w_tag;
  logic [WORDS-1:0][31:0] w_line;
  logic                 w_hit;
  logic                 w_last_beat;
  logic                 w_unused_ok;

  // The low address bits select bytes within a word and are ignored.
  assign w_unused_ok = ^CAddr[1:0];

  cache_line_store u_store (
    .clk         (CLK),
    .rst_n       (RST_n),
    .i_rd_index  (r_req_index),
    .o_rd_valid  (w_valid),
    .o_rd_dirty  (w_dirty),
    .o_rd_tag    (w_tag),
    .o_rd_line   (w_line),
    .i_wr_en     (w_st_we),
    .i_wr_index  (r_req_index),
    .i_wr_beat   (w_st_beat),
    .i_wr_data   (w_st_data),
    .i_wr_tag    (r_req_tag),
    .i_fill_done (w_st_fill_done),
    .i_set_dirty (w_st_set_dirty)
  );

  assign w_hit       = w_valid && (w_tag == r_req_tag);
  assign w_last_beat = (r_beat == LAST_BEAT);

  // State register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: line transfers advance only when the beat counter wraps.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:   if (CReq) w_next_state = ST_LOOKUP;
      ST_LOOKUP: begin
        if (w_hit)        w_next_state = ST_IDLE;
        else if (w_dirty) w_next_state = ST_WB;
        else              w_next_state = ST_FILL;
      end
      ST_WB:     if (w_last_beat) w_next_state = ST_FILL;
      ST_FILL:   if (w_last_beat) w_next_state = ST_LOOKUP;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered RAM/CPU drivers and line-store writes.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    w_nxt_beat     = r_beat;
    w_nxt_mrd      = 1'b1;
    w_nxt_cmwr     = 1'b0;
    w_nxt_addr     = r_addr;
    w_nxt_mdatain  = r_mdatain;
    w_nxt_cdataout = r_cdataout;
    w_nxt_cready   = 1'b0;
    w_nxt_busy     = r_busy;
    w_st_we        = 1'b0;
    w_st_beat      = r_beat;
    w_st_data      = MDataOut;
    w_st_fill_done = 1'b0;
    w_st_set_dirty = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (CReq) w_nxt_busy = 1'b1;
      end
      ST_LOOKUP: begin
        if (w_hit) begin
          w_nxt_cready = 1'b1;
          w_nxt_busy   = 1'b0;
          if (r_req_wr) begin
            w_st_we        = 1'b1;
            w_st_beat      = r_req_beat;
            w_st_data      = r_req_data;
            w_st_set_dirty = 1'b1;
          end else begin
            w_nxt_cdataout = w_line[r_req_beat];
          end
        end else if (w_dirty) begin
          w_nxt_beat    = '0;
          w_nxt_cmwr    = 1'b1;
          w_nxt_addr    = make_addr(w_tag, r_req_index, '0);
          w_nxt_mdatain = w_line[0];
        end else begin
          w_nxt_beat = '0;
          w_nxt_mrd  = 1'b0;
          w_nxt_addr = make_addr(r_req_tag, r_req_index, '0);
        end
      end
      ST_WB: begin
        if (w_last_beat) begin
          w_nxt_beat = '0;
          w_nxt_mrd  = 1'b0;
          w_nxt_addr = make_addr(r_req_tag, r_req_index, '0);
        end else begin
          w_nxt_beat    = r_beat + 1'b1;
          w_nxt_cmwr    = 1'b1;
          w_nxt_addr    = make_addr(w_tag, r_req_index, r_beat + 1'b1);
          w_nxt_mdatain = w_line[r_beat + 1'b1];
        end
      end
      ST_FILL: begin
        w_st_we = 1'b1;
        if (w_last_beat) begin
          w_nxt_beat     = '0;
          w_st_fill_done = 1'b1;
        end else begin
          w_nxt_beat = r_beat + 1'b1;
          w_nxt_mrd  = 1'b0;
          w_nxt_addr = make_addr(r_req_tag, r_req_index, r_beat + 1'b1);
        end
      end
      default: ;
    endcase
  end

  // Output and beat registers: all RAM-side signals come straight from flops.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_beat     <= '0;
      r_mrd      <= 1'b1;
      r_cmwr     <= 1'b0;
      r_addr     <= '0;
      r_mdatain  <= '0;
      r_cdataout <= '0;
      r_cready   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_beat     <= w_nxt_beat;
      r_mrd      <= w_nxt_mrd;
      r_cmwr     <= w_nxt_cmwr;
      r_addr     <= w_nxt_addr;
      r_mdatain  <= w_nxt_mdatain;
      r_cdataout <= w_nxt_cdataout;
      r_cready   <= w_nxt_cready;
      r_busy     <= w_nxt_busy;
    end
  end

  // Request latch: captured only when a request is accepted in IDLE.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_req_wr    <= 1'b0;
      r_req_tag   <= '0;
      r_req_index <= '0;
      r_req_beat  <= '0;
      r_req_data  <= '0;
    end else if (r_state == ST_IDLE && CReq) begin
      r_req_wr    <= CWr;
      r_req_tag   <= get_tag(CAddr);
      r_req_index <= get_index(CAddr);
      r_req_beat  <= get_beat(CAddr);
      r_req_data  <= CDataIn;
    end
  end

  assign CDataOut = r_cdataout;
  assign CReady   = r_cready;
  assign Busy     = r_busy;
  assign MRd      = r_mrd;
  assign CMWr     = r_cmwr;
  assign Addr     = r_addr;
  assign MDataIn  = r_mdatain;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl with a byte-array RAM model
// (combinational read, write while CMWr is high).
module tb_cache_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        CReq = 1'b0;
  logic        CWr = 1'b0;
  logic [31:0] CAddr = '0;
  logic [31:0] CDataIn = '0;
  logic [31:0] CDataOut;
  logic        CReady;
  logic        Busy;
  logic        MRd;
  logic        CMWr;
  logic [31:0] Addr;
  logic [31:0] MDataIn;
  logic [31:0] MDataOut;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  ram [0:1023];
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];

  always #5 CLK = ~CLK;

  cache_mem_ctrl dut (
    .CLK(CLK), .RST_n(RST_n), .CReq(CReq), .CWr(CWr), .CAddr(CAddr),
    .CDataIn(CDataIn), .CDataOut(CDataOut), .CReady(CReady), .Busy(Busy),
    .MRd(MRd), .CMWr(CMWr), .Addr(Addr), .MDataIn(MDataIn), .MDataOut(MDataOut)
  );

  // RAM read path (little-endian word at an aligned byte address).
  assign MDataOut = {ram[{Addr[9:2], 2'd3}], ram[{Addr[9:2], 2'd2}],
                     ram[{Addr[9:2], 2'd1}], ram[{Addr[9:2], 2'd0}]};

  // RAM write and beat log, sampled mid-cycle.
  always @(negedge CLK) begin
    if (CMWr) begin
      wr_q.push_back(Addr);
      ram[{Addr[9:2], 2'd0}] <= MDataIn[7:0];
      ram[{Addr[9:2], 2'd1}] <= MDataIn[15:8];
      ram[{Addr[9:2], 2'd2}] <= MDataIn[23:16];
      ram[{Addr[9:2], 2'd3}] <= MDataIn[31:24];
    end
    if (!MRd) rd_q.push_back(Addr);
  end

  function automatic logic [31:0] init_word(input int a);
    return (a == 0) ? 32'h1100F0F0 : (32'hA5A50000 ^ 32'(a));
  endfunction

  function automatic logic [31:0] ram_word(input int a);
    return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for CReady; lat counts negedges after the accept edge.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdata);
    @(negedge CLK);
    rd_q.delete();
    wr_q.delete();
    CReq = 1'b1; CWr = wr; CAddr = a; CDataIn = d;
    @(negedge CLK);
    CReq = 1'b0;
    lat = 1;
    while (!CReady && lat < 30) begin
      @(negedge CLK);
      lat++;
    end
    rdata = CDataOut;
    @(negedge CLK);
    check($sformatf("cready_pulse_0x%0h", a), {31'd0, CReady}, 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] wr_base;
    int          exp_rd;
    logic [31:0] rd_base;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int          lat;
    logic [31:0] rdata;
    int          pulses;
    int          pulse_cyc;

    for (int i = 0; i < 1024; i += 4) begin
      logic [31:0] w;
      w = init_word(i);
      ram[i] = w[7:0]; ram[i+1] = w[15:8]; ram[i+2] = w[23:16]; ram[i+3] = w[31:24];
    end

    //              wr    addr    wdata         exp_data               lat wr wr_base rd rd_base
    vecs[0] = '{1'b0, 32'h000, 32'h0,        32'h1100F0F0,          7,  0, 32'h0,  4, 32'h000};
    vecs[1] = '{1'b0, 32'h004, 32'h0,        init_word(32'h004),    2,  0, 32'h0,  0, 32'h000};
    vecs[2] = '{1'b1, 32'h008, 32'hDEADBEEF, 32'h0,                 2,  0, 32'h0,  0, 32'h000};
    vecs[3] = '{1'b0, 32'h088, 32'h0,        init_word(32'h088),    11, 4, 32'h0,  4, 32'h080};
    vecs[4] = '{1'b0, 32'h008, 32'h0,        32'hDEADBEEF,          7,  0, 32'h0,  4, 32'h000};
    vecs[5] = '{1'b0, 32'h1F4, 32'h0,        init_word(32'h1F4),    7,  0, 32'h0,  4, 32'h1F0};
    vecs[6] = '{1'b0, 32'h1F0, 32'h0,        init_word(32'h1F0),    2,  0, 32'h0,  0, 32'h000};
    vecs[7] = '{1'b1, 32'h1F8, 32'hCAFEF00D, 32'h0,                 2,  0, 32'h0,  0, 32'h000};
    vecs[8] = '{1'b0, 32'h1F8, 32'h0,        32'hCAFEF00D,          2,  0, 32'h0,  0, 32'h000};

    // Reset state while held.
    repeat (3) @(negedge CLK);
    check("rst_mrd",      {31'd0, MRd},    32'd1);
    check("rst_cmwr",     {31'd0, CMWr},   32'd0);
    check("rst_cready",   {31'd0, CReady}, 32'd0);
    check("rst_busy",     {31'd0, Busy},   32'd0);
    check("rst_addr",     Addr,            32'd0);
    check("rst_cdataout", CDataOut,        32'd0);
    RST_n = 1'b1;
    rd_q.delete(); wr_q.delete();
    repeat (5) @(negedge CLK);
    check("idle_rd_beats", 32'(rd_q.size()), 32'd0);
    check("idle_wr_beats", 32'(wr_q.size()), 32'd0);

    // Table-driven loads/stores: hits, clean misses, dirty miss with eviction.
    for (int v = 0; v < 9; v++) begin
      do_req(vecs[v].wr, vecs[v].addr, vecs[v].wdata, lat, rdata);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      if (!vecs[v].wr) check($sformatf("v%0d_data", v), rdata, vecs[v].exp_data);
      check($sformatf("v%0d_rd_beats", v), 32'(rd_q.size()), 32'(vecs[v].exp_rd));
      check($sformatf("v%0d_wr_beats", v), 32'(wr_q.size()), 32'(vecs[v].exp_wr));
      for (int b = 0; b < 4; b++) begin
        if (b < vecs[v].exp_rd && b < rd_q.size())
          check($sformatf("v%0d_rd_addr%0d", v, b), rd_q[b], vecs[v].rd_base + 32'(4*b));
        if (b < vecs[v].exp_wr && b < wr_q.size())
          check($sformatf("v%0d_wr_addr%0d", v, b), wr_q[b], vecs[v].wr_base + 32'(4*b));
      end
    end
    check("ram_0x08_written_back", ram_word(8), 32'hDEADBEEF);
    check("ram_0x00_written_back", ram_word(0), 32'h1100F0F0);

    // Reset during FILL beat 2 of a miss on 0x200 (index 0, clean line).
    @(negedge CLK);
    CReq = 1'b1; CWr = 1'b0; CAddr = 32'h200;
    @(negedge CLK);
    CReq = 1'b0;
    repeat (3) @(negedge CLK);
    check("fill_beat2_mrd",  {31'd0, MRd}, 32'd0);
    check("fill_beat2_addr", Addr,         32'h208);
    RST_n = 1'b0;
    #1;
    check("abort_mrd",  {31'd0, MRd},  32'd1);
    check("abort_cmwr", {31'd0, CMWr}, 32'd0);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_addr", Addr,          32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    do_req(1'b0, 32'h000, 32'h0, lat, rdata);
    check("post_reset_latency",  32'(lat), 32'd7);
    check("post_reset_data",     rdata,    32'h1100F0F0);
    check("post_reset_rd_beats", 32'(rd_q.size()), 32'd4);

    // Request pulsed while Busy must be ignored.
    @(negedge CLK);
    CReq = 1'b1; CWr = 1'b0; CAddr = 32'h300;
    pulses = 0; pulse_cyc = 0; rdata = '0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge CLK);
      if (c == 1) CReq = 1'b0;
      if (c == 2) begin
        CReq = 1'b1; CWr = 1'b1; CAddr = 32'h010; CDataIn = 32'h55555555;
      end
      if (c == 3) begin
        check("busy_mid_miss", {31'd0, Busy}, 32'd1);
        CReq = 1'b0;
      end
      if (CReady) begin
        pulses++;
        pulse_cyc = c;
        rdata = CDataOut;
      end
    end
    check("busy_req_pulses",  32'(pulses),    32'd1);
    check("busy_req_latency", 32'(pulse_cyc), 32'd7);
    check("busy_req_data",    rdata,          init_word(32'h300));
    do_req(1'b0, 32'h010, 32'h0, lat, rdata);
    check("ignored_store_data", rdata, init_word(32'h010));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
